// File: rtl/packet_receiver.sv
// Data-island packet sink: audio unpack to FIFO, ACR/AVI latching, drop and error counters.
// Latency: ACR/AVI/counters register one edge after the packet; audio pairs enter the FIFO one per cycle starting the edge after.
// Backpressure: audio_ready stalls the FIFO head; FIFO overflow and packets arriving mid-unpack are dropped and counted.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign rd_vld = (r_count != '0);
    assign w_rd   = rd_vld & rd_rdy;
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_rdy = ~w_full | w_rd;
    assign w_wr   = wr_vld & wr_rdy;
    assign rd_dat = r_mem[r_rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= wr_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module packet_receiver #(
    parameter int AUDIO_BIT_WIDTH          = 16,
    parameter int FIFO_DEPTH               = 8,
    parameter int INFOFRAME_TIMEOUT_FIELDS = 2
) (
    input  logic                            clk_pixel,
    input  logic                            reset_n,
    input  logic                            packet_valid,
    input  logic                            packet_error,
    input  logic [23:0]                     header,
    input  logic [3:0][55:0]                sub,
    input  logic                            video_field_end,
    output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic                            audio_valid,
    input  logic                            audio_ready,
    output logic [19:0]                     acr_n,
    output logic [19:0]                     acr_cts,
    output logic                            acr_update,
    output logic [6:0]                      video_id_code,
    output logic                            avi_present,
    output logic [7:0]                      drop_count,
    output logic [7:0]                      error_count
);
    localparam int W = AUDIO_BIT_WIDTH;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_UNPACK = 1'b1;

    logic [7:0]   w_hb0, w_hb1, w_hb2;
    logic         w_pkt, w_is_acr, w_is_aud, w_is_avi;
    logic         w_layout_err, w_aud_take, w_aud_drop;
    logic         w_avi_ok, w_avi_err, w_err_inc;
    logic [2:0]   w_pop;
    logic [223:0] w_sub_flat;
    logic [4:0]   w_pb_last;
    logic [7:0]   w_csum;
    logic [1:0]   w_sel;
    logic [3:0]   w_present_nxt;
    logic         w_wr_vld, w_wr_rdy, w_fifo_drop;
    logic [2*W-1:0] w_wr_dat;
    logic [3:0]   w_drop_add;
    logic [8:0]   w_drop_sum;
    logic         w_unused;

    logic [0:0]         r_state;
    logic [3:0]         r_present;
    logic [3:0][W-1:0]  r_hold_l;
    logic [3:0][W-1:0]  r_hold_r;
    logic [19:0]        r_acr_n, r_acr_cts;
    logic               r_acr_update;
    logic [6:0]         r_vic;
    logic               r_avi_present;
    logic [3:0]         r_field_cnt;
    logic [7:0]         r_drop, r_err;

    assign w_hb0 = header[7:0];
    assign w_hb1 = header[15:8];
    assign w_hb2 = header[23:16];
    assign w_unused = &{1'b0, w_hb1[7:5]};

    assign w_pkt        = packet_valid & ~packet_error;
    assign w_is_acr     = w_pkt && (w_hb0 == 8'h01);
    assign w_is_aud     = w_pkt && (w_hb0 == 8'h02);
    assign w_is_avi     = w_pkt && (w_hb0 == 8'h82);
    assign w_layout_err = w_is_aud & w_hb1[4];
    assign w_aud_take   = w_is_aud && !w_hb1[4] && (r_state == ST_IDLE) && (w_hb1[3:0] != 4'd0);
    assign w_aud_drop   = w_is_aud && !w_hb1[4] && (r_state == ST_UNPACK);
    assign w_pop = {2'b0, w_hb1[0]} + {2'b0, w_hb1[1]} + {2'b0, w_hb1[2]} + {2'b0, w_hb1[3]};

    // PBn sits at bit 8n of the flattened subpackets since each holds seven bytes.
    assign w_sub_flat = sub;
    always_comb begin
        w_pb_last = (w_hb2 > 8'd27) ? 5'd27 : w_hb2[4:0];
        w_csum    = w_hb0 + w_hb1 + w_hb2;
        for (int n = 0; n < 28; n++) begin
            if (5'(n) <= w_pb_last) w_csum = w_csum + w_sub_flat[8*n +: 8];
        end
    end
    assign w_avi_ok  = w_is_avi && (w_csum == 8'd0);
    assign w_avi_err = w_is_avi && (w_csum != 8'd0);
    assign w_err_inc = packet_error | w_layout_err | w_avi_err;

    always_comb begin
        w_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_present[i]) w_sel = 2'(i);
        end
    end
    assign w_present_nxt = r_present & ~(4'b0001 << w_sel);
    assign w_wr_vld      = (r_state == ST_UNPACK);
    assign w_wr_dat      = {r_hold_r[w_sel], r_hold_l[w_sel]};
    assign w_fifo_drop   = w_wr_vld & ~w_wr_rdy;

    fifo #(.WIDTH(2*W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .core_clk (clk_pixel),
        .arst_n   (reset_n),
        .wr_vld   (w_wr_vld),
        .wr_dat   (w_wr_dat),
        .wr_rdy   (w_wr_rdy),
        .rd_vld   (audio_valid),
        .rd_dat   (audio_sample_word),
        .rd_rdy   (audio_ready)
    );

    assign w_drop_add = (w_aud_drop ? {1'b0, w_pop} : 4'd0) + {3'b0, w_fifo_drop};
    assign w_drop_sum = {1'b0, r_drop} + {5'b0, w_drop_add};

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_present <= '0;
            r_hold_l  <= '0;
            r_hold_r  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_aud_take) begin
                r_state   <= ST_UNPACK;
                r_present <= w_hb1[3:0];
                for (int i = 0; i < 4; i++) begin
                    r_hold_l[i] <= sub[i][W-1:0];
                    r_hold_r[i] <= sub[i][24 +: W];
                end
            end
        end else begin
            r_present <= w_present_nxt;
            if (w_present_nxt == 4'd0) r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_acr_n       <= '0;
            r_acr_cts     <= '0;
            r_acr_update  <= 1'b0;
            r_vic         <= '0;
            r_avi_present <= 1'b0;
            r_field_cnt   <= '0;
            r_drop        <= '0;
            r_err         <= '0;
        end else begin
            r_acr_update <= w_is_acr;
            if (w_is_acr) begin
                r_acr_cts <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
                r_acr_n   <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
            end
            // A valid AVI takes priority over a coincident field end.
            if (w_avi_ok) begin
                r_vic         <= sub[0][38:32];
                r_avi_present <= 1'b1;
                r_field_cnt   <= '0;
            end else if (video_field_end && r_avi_present) begin
                if (r_field_cnt + 4'd1 == 4'(INFOFRAME_TIMEOUT_FIELDS)) begin
                    r_avi_present <= 1'b0;
                    r_field_cnt   <= '0;
                end else begin
                    r_field_cnt <= r_field_cnt + 4'd1;
                end
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    assign acr_n         = r_acr_n;
    assign acr_cts       = r_acr_cts;
    assign acr_update    = r_acr_update;
    assign video_id_code = r_vic;
    assign avi_present   = r_avi_present;
    assign drop_count    = r_drop;
    assign error_count   = r_err;
endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver; audio pairs are checked by a queue-driven monitor.
module tb_packet_receiver;
    logic             clk_pixel = 1'b0;
    logic             reset_n;
    logic             packet_valid;
    logic             packet_error;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             video_field_end;
    logic [1:0][15:0] audio_sample_word;
    logic             audio_valid;
    logic             audio_ready;
    logic [19:0]      acr_n;
    logic [19:0]      acr_cts;
    logic             acr_update;
    logic [6:0]       video_id_code;
    logic             avi_present;
    logic [7:0]       drop_count;
    logic [7:0]       error_count;

    always #5 clk_pixel = ~clk_pixel;

    packet_receiver #(
        .AUDIO_BIT_WIDTH(16), .FIFO_DEPTH(8), .INFOFRAME_TIMEOUT_FIELDS(2)
    ) dut (
        .clk_pixel         (clk_pixel),
        .reset_n           (reset_n),
        .packet_valid      (packet_valid),
        .packet_error      (packet_error),
        .header            (header),
        .sub               (sub),
        .video_field_end   (video_field_end),
        .audio_sample_word (audio_sample_word),
        .audio_valid       (audio_valid),
        .audio_ready       (audio_ready),
        .acr_n             (acr_n),
        .acr_cts           (acr_cts),
        .acr_update        (acr_update),
        .video_id_code     (video_id_code),
        .avi_present       (avi_present),
        .drop_count        (drop_count),
        .error_count       (error_count)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected pairs are {right, left}; a transfer is decided at this negedge and happens next posedge.
    always @(negedge clk_pixel) begin
        if (reset_n && audio_valid && audio_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL audio_unexpected actual=0x%0h required=none", audio_sample_word);
            end else begin
                chk("audio_pair", audio_sample_word, exp_q.pop_front());
            end
        end
    end

    function automatic logic [55:0] mk_sub(input logic [15:0] l, input logic [15:0] r);
        return {16'hC3C3, r, 8'h5A, l};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    task automatic pkt(input logic [23:0] h, input logic [3:0][55:0] s, input logic err);
        header       = h;
        sub          = s;
        packet_valid = 1'b1;
        packet_error = err;
        @(posedge clk_pixel);
        #1;
        packet_valid = 1'b0;
        packet_error = 1'b0;
    endtask

    task automatic fe();
        video_field_end = 1'b1;
        @(posedge clk_pixel);
        #1;
        video_field_end = 1'b0;
    endtask

    logic [3:0][55:0] s;
    logic [15:0]      l16, r16;
    logic [3:0][55:0] avi16;
    logic [3:0][55:0] avi5_bad;

    initial begin
        reset_n = 1'b0; packet_valid = 1'b0; packet_error = 1'b0;
        header = '0; sub = '0; video_field_end = 1'b0; audio_ready = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1;
        chk("rst_audio_valid", 32'(audio_valid), 32'd0);
        chk("rst_sample_word", audio_sample_word, 32'd0);
        chk("rst_acr_n", 32'(acr_n), 32'd0);
        chk("rst_acr_cts", 32'(acr_cts), 32'd0);
        chk("rst_acr_update", 32'(acr_update), 32'd0);
        chk("rst_vic", 32'(video_id_code), 32'd0);
        chk("rst_avi_present", 32'(avi_present), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_err", 32'(error_count), 32'd0);
        reset_n = 1'b1;
        cyc(1);

        // ACR: bytes b6..b0 = 80 18 00 B0 71 0B 00
        s = '0;
        s[0] = 56'h80_18_00_B0_71_0B_00;
        pkt(24'h000001, s, 1'b0);
        chk("acr_update_pulse", 32'(acr_update), 32'd1);
        chk("acr_cts", 32'(acr_cts), 32'h000B71B0);
        chk("acr_n", 32'(acr_n), 32'h00001880);
        cyc(1);
        chk("acr_update_clear", 32'(acr_update), 32'd0);

        // Audio HB1=0x0B: subpackets 0,1,3 present, 2 skipped
        audio_ready = 1'b1;
        s[0] = mk_sub(16'h1111, 16'h2222);
        s[1] = mk_sub(16'h3333, 16'h4444);
        s[2] = mk_sub(16'h5555, 16'h6666);
        s[3] = mk_sub(16'h7777, 16'h8888);
        exp_q.push_back({16'h2222, 16'h1111});
        exp_q.push_back({16'h4444, 16'h3333});
        exp_q.push_back({16'h8888, 16'h7777});
        pkt(24'h000B02, s, 1'b0);
        cyc(8);
        chk("aud_drop_zero", 32'(drop_count), 32'd0);
        chk("aud_drained", 32'(audio_valid), 32'd0);
        chk("aud_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overflow: three full packets with the consumer stalled
        audio_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) begin
                l16 = 16'(32'h1000 + p * 16 + i);
                r16 = 16'(32'h2000 + p * 16 + i);
                s[i] = mk_sub(l16, r16);
                if (p < 2) exp_q.push_back({r16, l16});
            end
            pkt(24'h000F02, s, 1'b0);
            cyc(5);
        end
        chk("ovf_drop", 32'(drop_count), 32'd4);
        chk("ovf_valid", 32'(audio_valid), 32'd1);
        chk("ovf_head", audio_sample_word, {16'h2000, 16'h1000});
        cyc(3);
        chk("ovf_head_stable", audio_sample_word, {16'h2000, 16'h1000});
        audio_ready = 1'b1;
        cyc(12);
        chk("ovf_drained", 32'(audio_valid), 32'd0);
        chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

        // Packet arriving mid-unpack is dropped by popcount
        s[0] = mk_sub(16'hAAAA, 16'hBBBB);
        s[1] = mk_sub(16'hCCCC, 16'hDDDD);
        exp_q.push_back({16'hBBBB, 16'hAAAA});
        exp_q.push_back({16'hDDDD, 16'hCCCC});
        pkt(24'h000302, s, 1'b0);
        pkt(24'h000502, s, 1'b0);
        cyc(5);
        chk("busy_drop", 32'(drop_count), 32'd6);
        chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);

        // Layout bit set
        pkt(24'h001302, s, 1'b0);
        cyc(3);
        chk("layout_err", 32'(error_count), 32'd1);
        chk("layout_no_write", 32'(audio_valid), 32'd0);

        // AVI VIC=16, HB2=13; PB14 (0x55) lies beyond the length and is excluded
        avi16 = '0;
        avi16[0] = 56'h00_00_10_00_00_10_4F;
        avi16[2] = 56'h00_00_00_00_00_00_55;
        pkt(24'h0D0282, avi16, 1'b0);
        chk("avi_vic", 32'(video_id_code), 32'd16);
        chk("avi_present", 32'(avi_present), 32'd1);
        chk("avi_err_same", 32'(error_count), 32'd1);
        avi5_bad = avi16;
        avi5_bad[0] = 56'h00_00_05_00_00_10_5B;
        pkt(24'h0D0282, avi5_bad, 1'b0);
        chk("avi_bad_vic", 32'(video_id_code), 32'd16);
        chk("avi_bad_err", 32'(error_count), 32'd2);

        // Timeout after two field ends
        fe();
        chk("to_first_field", 32'(avi_present), 32'd1);
        fe();
        chk("to_cleared", 32'(avi_present), 32'd0);
        chk("to_vic_kept", 32'(video_id_code), 32'd16);
        pkt(24'h0D0282, avi16, 1'b0);
        chk("to_reacquire", 32'(avi_present), 32'd1);
        video_field_end = 1'b1;
        pkt(24'h0D0282, avi16, 1'b0);
        video_field_end = 1'b0;
        fe();
        chk("to_avi_wins", 32'(avi_present), 32'd1);
        fe();
        chk("to_after_win", 32'(avi_present), 32'd0);

        // packet_error overrides packet_valid
        s = '0;
        s[0] = 56'h11_22_03_44_55_06_00;
        pkt(24'h000001, s, 1'b1);
        chk("err_no_acr_update", 32'(acr_update), 32'd0);
        chk("err_acr_kept", 32'(acr_cts), 32'h000B71B0);
        chk("err_count", 32'(error_count), 32'd3);

        packet_error = 1'b1;
        repeat (260) @(posedge clk_pixel);
        #1;
        packet_error = 1'b0;
        chk("err_saturate", 32'(error_count), 32'd255);

        // Reset during unpack with consumer stalled
        audio_ready = 1'b0;
        for (int i = 0; i < 4; i++) s[i] = mk_sub(16'(32'h9000 + i), 16'(32'h9100 + i));
        pkt(24'h000F02, s, 1'b0);
        cyc(1);
        chk("pre_rst_valid", 32'(audio_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(audio_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        chk("mid_rst_err", 32'(error_count), 32'd0);
        chk("mid_rst_acr_n", 32'(acr_n), 32'd0);
        chk("mid_rst_vic", 32'(video_id_code), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        chk("post_rst_idle", 32'(audio_valid), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
